// File: rtl/mnk_game_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mnk_game_ctrl_pkg                                          |
// | Purpose : Shared definitions for the m,n,k board-game controller:    |
// |           cell codes, FSM state encoding and the scan direction      |
// |           table (row, column, diagonal, anti-diagonal).              |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mnk_game_ctrl_pkg;

  // Cell codes held in the board registers.
  localparam logic [1:0] c_EMPTY = 2'b00;
  localparam logic [1:0] c_P1    = 2'b01;
  localparam logic [1:0] c_P2    = 2'b10;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Direction index encoding, scanned in this order.
  localparam logic [1:0] c_DIR_ROW  = 2'd0;  // (dr,dc) = ( 0,+1)
  localparam logic [1:0] c_DIR_COL  = 2'd1;  // (dr,dc) = (+1, 0)
  localparam logic [1:0] c_DIR_DIAG = 2'd2;  // (dr,dc) = (+1,+1)
  localparam logic [1:0] c_DIR_ANTI = 2'd3;  // (dr,dc) = (+1,-1)

  function automatic logic signed [1:0] dir_dr(input logic [1:0] dir);
    return (dir == c_DIR_ROW) ? 2'sd0 : 2'sd1;
  endfunction

  function automatic logic signed [1:0] dir_dc(input logic [1:0] dir);
    logic signed [1:0] d;
    case (dir)
      c_DIR_ROW:  d = 2'sd1;
      c_DIR_COL:  d = 2'sd0;
      c_DIR_DIAG: d = 2'sd1;
      default:    d = -2'sd1;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] player_code(input logic player);
    return player ? c_P2 : c_P1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mnk_game_ctrl_dir_walker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mnk_game_ctrl_dir_walker                                   |
// | Purpose : Walks the line scan around a freshly placed stone. For     |
// |           each of the four directions it visits K-1 cells on the +   |
// |           side, then K-1 cells on the - side, one cell per step.     |
// |           Coordinates are only ever incremented/decremented.         |
// | Ports   : clk, resetn (sync, active-low), i_clear (sync clear),      |
// |           i_start (load origin), i_step (advance one cell),          |
// |           i_org_row/i_org_col (origin), o_row/o_col (cell being      |
// |           examined), o_in_range, o_side_end, o_dir_end, o_scan_end   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mnk_game_ctrl_dir_walker
  import mnk_game_ctrl_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_clear,
  input  logic          i_start,
  input  logic          i_step,
  input  logic [CW-1:0] i_org_row,
  input  logic [CW-1:0] i_org_col,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_in_range,
  output logic          o_side_end,
  output logic          o_dir_end,
  output logic          o_scan_end
);

  // Two extra bits: one sign bit for cells left/above the board and one
  // for cells up to K-1 beyond the far edge.
  localparam int SW  = CW + 2;
  localparam int STW = $clog2(K);
  localparam logic [STW-1:0]       c_LAST_STEP = STW'(K - 2);
  localparam logic signed [SW-1:0] c_NS        = SW'(N);

  function automatic logic signed [SW-1:0] ext2(input logic signed [1:0] d);
    return {{(SW-2){d[1]}}, d};
  endfunction

  logic signed [SW-1:0] r_org_row, r_org_col, r_row, r_col;
  logic [1:0]           r_dir;
  logic                 r_side;   // 0 = walking + side, 1 = walking - side
  logic [STW-1:0]       r_step;

  logic signed [SW-1:0] w_dr, w_dc, w_ndr, w_ndc, w_org_row_in, w_org_col_in;

  assign w_dr         = ext2(dir_dr(r_dir));
  assign w_dc         = ext2(dir_dc(r_dir));
  assign w_ndr        = ext2(dir_dr(r_dir + 2'd1));
  assign w_ndc        = ext2(dir_dc(r_dir + 2'd1));
  assign w_org_row_in = $signed({2'b00, i_org_row});
  assign w_org_col_in = $signed({2'b00, i_org_col});

  assign o_side_end = (r_step == c_LAST_STEP);
  assign o_dir_end  = o_side_end && r_side;
  assign o_scan_end = o_dir_end && (r_dir == c_DIR_ANTI);
  assign o_in_range = !r_row[SW-1] && !r_col[SW-1] && (r_row < c_NS) && (r_col < c_NS);
  assign o_row      = r_row[CW-1:0];
  assign o_col      = r_col[CW-1:0];

  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_org_row <= '0;
      r_org_col <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_dir     <= c_DIR_ROW;
      r_side    <= 1'b0;
      r_step    <= '0;
    end else if (i_start) begin
      r_org_row <= w_org_row_in;
      r_org_col <= w_org_col_in;
      r_row     <= w_org_row_in + ext2(dir_dr(c_DIR_ROW));
      r_col     <= w_org_col_in + ext2(dir_dc(c_DIR_ROW));
      r_dir     <= c_DIR_ROW;
      r_side    <= 1'b0;
      r_step    <= '0;
    end else if (i_step) begin
      if (o_side_end) begin
        r_step <= '0;
        if (!r_side) begin
          // Turn around: restart one cell on the other side of the origin.
          r_side <= 1'b1;
          r_row  <= r_org_row - w_dr;
          r_col  <= r_org_col - w_dc;
        end else begin
          r_side <= 1'b0;
          r_dir  <= r_dir + 2'd1;
          r_row  <= r_org_row + w_ndr;
          r_col  <= r_org_col + w_ndc;
        end
      end else begin
        r_step <= r_step + STW'(1);
        if (!r_side) begin
          r_row <= r_row + w_dr;
          r_col <= r_col + w_dc;
        end else begin
          r_row <= r_row - w_dr;
          r_col <= r_col - w_dc;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mnk_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mnk_game_ctrl                                              |
// | Purpose : N x N, K-in-a-row two-player game controller. Takes one    |
// |           move per handshake, enforces turn order, rejects illegal   |
// |           moves and runs a fixed-length line scan through each       |
// |           accepted stone to detect a win or a draw.                  |
// | Ports   : clk, resetn (sync, active-low), new_game (sync restart),   |
// |           move_valid/move_player/move_row/move_col (request),        |
// |           move_ready, turn, ilg1/ilg2 (reject pulses),               |
// |           p1/p2/nospace (sticky result flags)                        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mnk_game_ctrl
  import mnk_game_ctrl_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int K     = 3,
  parameter  int FIRST = 0,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          new_game,
  input  logic          move_valid,
  input  logic          move_player,
  input  logic [CW-1:0] move_row,
  input  logic [CW-1:0] move_col,
  output logic          move_ready,
  output logic          turn,
  output logic          ilg1,
  output logic          ilg2,
  output logic          p1,
  output logic          p2,
  output logic          nospace
);

  localparam int CNTW = $clog2(N*N + 1);
  localparam int RW   = $clog2(2*K);     // holds a run of up to 2K-1
  localparam int CW1  = CW + 1;
  localparam logic [CNTW-1:0] c_CELLS = CNTW'(N*N);
  localparam logic [RW-1:0]   c_K_RUN = RW'(K);
  localparam logic [CW1-1:0]  c_N_EXT = CW1'(N);

  state_t          r_state;
  logic [1:0]      r_board [N][N];
  logic [CNTW-1:0] r_count;
  logic            r_turn, r_ready, r_ilg1, r_ilg2, r_p1, r_p2, r_nospace;
  logic [RW-1:0]   r_run;    // 1 (placed stone) + matches so far in this direction
  logic            r_alive;  // current side still unbroken
  logic            r_win;
  logic            r_done;   // scan finished, next edge publishes the result

  logic          w_tgt_in, w_legal, w_accept, w_step, w_hit;
  logic [1:0]    w_tgt_cell, w_scan_cell;
  logic [RW-1:0] w_run_nx;
  logic [CW-1:0] w_wk_row, w_wk_col;
  logic          w_wk_in, w_side_end, w_dir_end, w_scan_end;

  assign w_tgt_in   = ({1'b0, move_row} < c_N_EXT) && ({1'b0, move_col} < c_N_EXT);
  assign w_tgt_cell = w_tgt_in ? r_board[move_row][move_col] : c_EMPTY;
  assign w_legal    = (move_player == r_turn) && w_tgt_in && (w_tgt_cell == c_EMPTY);
  assign w_accept   = (r_state == ST_PLAY) && move_valid && w_legal;
  assign w_step     = (r_state == ST_CHECK) && !r_done;

  // Off-board cells read as EMPTY, which never matches the mover.
  assign w_scan_cell = w_wk_in ? r_board[w_wk_row][w_wk_col] : c_EMPTY;
  assign w_hit       = r_alive && (w_scan_cell == player_code(r_turn));
  assign w_run_nx    = r_run + {{(RW-1){1'b0}}, w_hit};

  mnk_game_ctrl_dir_walker #(
    .N  (N),
    .K  (K),
    .CW (CW)
  ) u_walker (
    .clk        (clk),
    .resetn     (resetn),
    .i_clear    (new_game),
    .i_start    (w_accept),
    .i_step     (w_step),
    .i_org_row  (move_row),
    .i_org_col  (move_col),
    .o_row      (w_wk_row),
    .o_col      (w_wk_col),
    .o_in_range (w_wk_in),
    .o_side_end (w_side_end),
    .o_dir_end  (w_dir_end),
    .o_scan_end (w_scan_end)
  );

  always_ff @(posedge clk) begin
    if (!resetn || new_game) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_board[r][c] <= c_EMPTY;
        end
      end
      r_state   <= ST_PLAY;
      r_count   <= '0;
      r_turn    <= 1'(FIRST);
      r_ready   <= 1'b1;
      r_ilg1    <= 1'b0;
      r_ilg2    <= 1'b0;
      r_p1      <= 1'b0;
      r_p2      <= 1'b0;
      r_nospace <= 1'b0;
      r_run     <= RW'(1);
      r_alive   <= 1'b1;
      r_win     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_ilg1 <= 1'b0;
      r_ilg2 <= 1'b0;
      case (r_state)
        ST_PLAY: begin
          if (move_valid) begin
            if (w_legal) begin
              r_board[move_row][move_col] <= player_code(r_turn);
              r_count <= r_count + CNTW'(1);
              r_state <= ST_CHECK;
              r_ready <= 1'b0;
              r_run   <= RW'(1);
              r_alive <= 1'b1;
              r_win   <= 1'b0;
              r_done  <= 1'b0;
            end else if (move_player) begin
              r_ilg2 <= 1'b1;
            end else begin
              r_ilg1 <= 1'b1;
            end
          end
        end

        ST_CHECK: begin
          if (!r_done) begin
            if (w_dir_end) begin
              if (w_run_nx >= c_K_RUN) begin
                r_win <= 1'b1;
              end
              r_run   <= RW'(1);
              r_alive <= 1'b1;
            end else if (w_side_end) begin
              r_run   <= w_run_nx;
              r_alive <= 1'b1;
            end else begin
              r_run   <= w_run_nx;
              r_alive <= w_hit;
            end
            if (w_scan_end) begin
              r_done <= 1'b1;
            end
          end else begin
            // Win takes precedence over a full board.
            if (r_win) begin
              if (r_turn) begin
                r_p2 <= 1'b1;
              end else begin
                r_p1 <= 1'b1;
              end
              r_state <= ST_OVER;
            end else if (r_count == c_CELLS) begin
              r_nospace <= 1'b1;
              r_state   <= ST_OVER;
            end else begin
              r_turn  <= ~r_turn;
              r_state <= ST_PLAY;
              r_ready <= 1'b1;
            end
          end
        end

        ST_OVER: begin
          r_ready <= 1'b0;
        end

        default: begin
          r_state <= ST_PLAY;
        end
      endcase
    end
  end

  assign move_ready = r_ready;
  assign turn       = r_turn;
  assign ilg1       = r_ilg1;
  assign ilg2       = r_ilg2;
  assign p1         = r_p1;
  assign p2         = r_p2;
  assign nospace    = r_nospace;

endmodule
`default_nettype wire

// File: tb/tb_mnk_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mnk_game_ctrl                                           |
// | Purpose : Scoreboard bench for mnk_game_ctrl. Instance A is N=3 K=3, |
// |           instance B is N=5 K=4. Stimulus queues expected events;    |
// |           per-instance monitors pop and compare whenever the DUT     |
// |           shows a reject pulse, a result/ready edge or a probe.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_mnk_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn = 1'b0;
  logic       a_ng = 1'b0, a_mv = 1'b0, a_pl = 1'b0;
  logic [1:0] a_row = '0, a_col = '0;
  logic       a_ready, a_turn, a_ilg1, a_ilg2, a_p1, a_p2, a_ns;
  logic       b_ng = 1'b0, b_mv = 1'b0, b_pl = 1'b0;
  logic [2:0] b_row = '0, b_col = '0;
  logic       b_ready, b_turn, b_ilg1, b_ilg2, b_p1, b_p2, b_ns;

  mnk_game_ctrl #(.N(3), .K(3), .FIRST(0)) u_a (
    .clk(clk), .resetn(resetn), .new_game(a_ng), .move_valid(a_mv),
    .move_player(a_pl), .move_row(a_row), .move_col(a_col),
    .move_ready(a_ready), .turn(a_turn), .ilg1(a_ilg1), .ilg2(a_ilg2),
    .p1(a_p1), .p2(a_p2), .nospace(a_ns)
  );

  mnk_game_ctrl #(.N(5), .K(4), .FIRST(0)) u_b (
    .clk(clk), .resetn(resetn), .new_game(b_ng), .move_valid(b_mv),
    .move_player(b_pl), .move_row(b_row), .move_col(b_col),
    .move_ready(b_ready), .turn(b_turn), .ilg1(b_ilg1), .ilg2(b_ilg2),
    .p1(b_p1), .p2(b_p2), .nospace(b_ns)
  );

  // Expected flags packed as {ilg1, ilg2, p1, p2, nospace, move_ready, turn}.
  typedef struct {
    int         dut;
    string      tag;
    logic [6:0] flags;
    int         lat;     // edges since accept; -1 = not checked
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  logic probe_a = 1'b0, probe_b = 1'b0;

  function automatic void expect_ev(input int dut, input string tag,
                                    input logic [6:0] f, input int lat);
    exp_t e;
    e.dut = dut; e.tag = tag; e.flags = f; e.lat = lat;
    sb.push_back(e);
  endfunction

  task automatic score(input int dut, input logic [6:0] obs, input int lat);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: dut%0d flags=%b lat=%0d, required no event", dut, obs, lat);
      return;
    end
    e = sb.pop_front();
    if (e.dut != dut || e.flags !== obs || (e.lat >= 0 && e.lat != lat)) begin
      n_err++;
      $display("FAIL %s: got dut%0d flags=%b lat=%0d, required dut%0d flags=%b lat=%0d",
               e.tag, dut, obs, lat, e.dut, e.flags, e.lat);
    end
  endtask

  // Monitor A
  logic a_pr = 1'b0, a_pp1 = 1'b0, a_pp2 = 1'b0, a_pns = 1'b0;
  int   a_lat = 0;
  always @(negedge clk) begin
    if (a_pr && !a_ready) a_lat = 0; else a_lat = a_lat + 1;
    if (mon_en && (probe_a || a_ilg1 || a_ilg2 || (a_ready && !a_pr) ||
                   (a_p1 && !a_pp1) || (a_p2 && !a_pp2) || (a_ns && !a_pns)))
      score(0, {a_ilg1, a_ilg2, a_p1, a_p2, a_ns, a_ready, a_turn}, a_lat);
    a_pr = a_ready; a_pp1 = a_p1; a_pp2 = a_p2; a_pns = a_ns;
  end

  // Monitor B
  logic b_pr = 1'b0, b_pp1 = 1'b0, b_pp2 = 1'b0, b_pns = 1'b0;
  int   b_lat = 0;
  always @(negedge clk) begin
    if (b_pr && !b_ready) b_lat = 0; else b_lat = b_lat + 1;
    if (mon_en && (probe_b || b_ilg1 || b_ilg2 || (b_ready && !b_pr) ||
                   (b_p1 && !b_pp1) || (b_p2 && !b_pp2) || (b_ns && !b_pns)))
      score(1, {b_ilg1, b_ilg2, b_p1, b_p2, b_ns, b_ready, b_turn}, b_lat);
    b_pr = b_ready; b_pp1 = b_p1; b_pp2 = b_p2; b_pns = b_ns;
  end

  task automatic req(input int dut, input bit p, input int r, input int c);
    @(posedge clk); #1;
    if (dut == 0) begin a_mv = 1'b1; a_pl = p; a_row = r[1:0]; a_col = c[1:0]; end
    else          begin b_mv = 1'b1; b_pl = p; b_row = r[2:0]; b_col = c[2:0]; end
    @(posedge clk); #1;
    a_mv = 1'b0; b_mv = 1'b0;
  endtask

  task automatic pulse_ng(input int dut);
    @(posedge clk); #1;
    if (dut == 0) a_ng = 1'b1; else b_ng = 1'b1;
    @(posedge clk); #1;
    a_ng = 1'b0; b_ng = 1'b0;
  endtask

  task automatic probe(input int dut);
    @(posedge clk); #1;
    if (dut == 0) probe_a = 1'b1; else probe_b = 1'b1;
    @(posedge clk); #1;
    probe_a = 1'b0; probe_b = 1'b0;
  endtask

  task automatic wait_result(input int dut);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (dut == 0) done = a_ready || a_p1 || a_p2 || a_ns;
      else          done = b_ready || b_p1 || b_p2 || b_ns;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL wait_result: dut%0d still busy after 60 cycles, required a result", dut);
    end
  endtask

  // Legal move: expected flags after the scan, latency 8*(K-1)+1.
  task automatic legal(input int dut, input string tag, input bit p, input int r,
                       input int c, input logic [6:0] f);
    expect_ev(dut, tag, f, (dut == 0) ? 17 : 25);
    req(dut, p, r, c);
    wait_result(dut);
  endtask

  task automatic illegal(input int dut, input string tag, input bit p, input int r,
                         input int c, input logic [6:0] f);
    expect_ev(dut, tag, f, -1);
    req(dut, p, r, c);
    @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    mon_en = 1'b1;

    // Reset state: ready=1, turn=FIRST, no flags.
    expect_ev(0, "a_reset", 7'b0000010, -1); probe(0);
    expect_ev(1, "b_reset", 7'b0000010, -1); probe(1);

    // Diagonal win for P1 on the 3x3 board.
    legal(0, "win_m1", 1'b0, 0, 0, 7'b0000011);
    legal(0, "win_m2", 1'b1, 0, 1, 7'b0000010);
    legal(0, "win_m3", 1'b0, 1, 1, 7'b0000011);
    legal(0, "win_m4", 1'b1, 0, 2, 7'b0000010);
    legal(0, "win_m5", 1'b0, 2, 2, 7'b0010000);
    req(0, 1'b0, 1, 0);                 // OVER: must be ignored
    repeat (3) @(posedge clk);

    // Illegal requests.
    expect_ev(0, "ng_from_over", 7'b0000010, -1); pulse_ng(0);
    illegal(0, "ilg_p2_first",  1'b1, 0, 0, 7'b0100010);
    legal  (0, "ilg_setup_p1",  1'b0, 0, 0, 7'b0000011);
    illegal(0, "ilg_occupied",  1'b1, 0, 0, 7'b0100011);
    illegal(0, "ilg_p1_turn",   1'b0, 2, 2, 7'b1000011);
    legal  (0, "ilg_setup_p2",  1'b1, 1, 1, 7'b0000010);
    illegal(0, "ilg_row_oob",   1'b0, 3, 0, 7'b1000010);
    illegal(0, "ilg_col_oob",   1'b0, 0, 3, 7'b1000010);

    // Draw: new_game from PLAY raises no ready edge, so probe it.
    pulse_ng(0);
    expect_ev(0, "ng_from_play", 7'b0000010, -1); probe(0);
    legal(0, "draw_m1", 1'b0, 0, 0, 7'b0000011);
    legal(0, "draw_m2", 1'b1, 0, 1, 7'b0000010);
    legal(0, "draw_m3", 1'b0, 0, 2, 7'b0000011);
    legal(0, "draw_m4", 1'b1, 1, 1, 7'b0000010);
    legal(0, "draw_m5", 1'b0, 1, 0, 7'b0000011);
    legal(0, "draw_m6", 1'b1, 1, 2, 7'b0000010);
    legal(0, "draw_m7", 1'b0, 2, 1, 7'b0000011);
    legal(0, "draw_m8", 1'b1, 2, 0, 7'b0000010);
    legal(0, "draw_m9", 1'b0, 2, 2, 7'b0000100);

    // new_game mid-CHECK aborts the scan, ready returns 5 edges after accept.
    expect_ev(0, "ng_after_draw", 7'b0000010, -1); pulse_ng(0);
    expect_ev(0, "abort_clear", 7'b0000010, 5);
    req(0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    pulse_ng(0);
    // Same cell is legal again; a request during CHECK is ignored.
    expect_ev(0, "post_abort_m1", 7'b0000011, 17);
    req(0, 1'b0, 0, 0);
    req(0, 1'b1, 1, 1);
    wait_result(0);
    legal(0, "post_abort_m2", 1'b1, 1, 1, 7'b0000010);

    // 5x5, K=4: P2 anti-diagonal completed in the middle.
    legal(1, "b_m1", 1'b0, 0, 0, 7'b0000011);
    legal(1, "b_m2", 1'b1, 0, 3, 7'b0000010);
    legal(1, "b_m3", 1'b0, 4, 4, 7'b0000011);
    legal(1, "b_m4", 1'b1, 3, 0, 7'b0000010);
    legal(1, "b_m5", 1'b0, 2, 4, 7'b0000011);
    legal(1, "b_m6", 1'b1, 2, 1, 7'b0000010);
    legal(1, "b_m7", 1'b0, 4, 1, 7'b0000011);
    legal(1, "b_m8", 1'b1, 1, 2, 7'b0001001);

    repeat (5) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++; n_err++;
      $display("FAIL %s: no event seen on dut%0d, required flags=%b", e.tag, e.dut, e.flags);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
